// File: rtl/display_pkg.sv
// display_pkg: opcodes, sequencer state encoding and default payload width
package display_pkg;
   localparam int DATA_W_DEF = 8;
   localparam logic [1:0] OP_DATA  = 2'b00;
   localparam logic [1:0] OP_CMD   = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_RESET = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DELAY, ST_RESET} state_t;
endpackage

// File: rtl/display_word_shifter.sv
// display_word_shifter: MSB-first word shift register with bit counter and last-bit flag
module display_word_shifter
   import display_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              mosi,
   output logic              last
);
   localparam int BW = $clog2(DATA_W + 1);
   logic [DATA_W-1:0] sr;
   logic [BW-1:0]     cnt;
   // load a fresh word, or move one bit out per serial strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= din;
         cnt <= BW'(DATA_W);
      end else if (shift) begin
         sr  <= sr << 1;
         cnt <= cnt - BW'(1);
      end
   end
   assign mosi = sr[DATA_W-1];
   assign last = cnt == BW'(1);
endmodule

// File: rtl/display_instr_sequencer.sv
// display_instr_sequencer: decodes write/delay/reset instructions and drives the display pins
// Optional macro CS_HOLD_EN keeps cs low between consecutive writes.
module display_instr_sequencer
   import display_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DELAY_SHIFT = 4,
   parameter int RES_EDGES   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk_edge,
   input  logic              instr_valid,
   input  logic [DATA_W+1:0] instr,
   output logic              instr_ready,
   output logic              cs,
   output logic              dc,
   output logic              res_n,
   output logic              mosi,
   output logic              busy,
   output logic              done
);
   localparam int DW = DATA_W + DELAY_SHIFT;
   localparam int RW = $clog2(RES_EDGES + 1);
   localparam int CW = DW > RW ? DW : RW;
   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic              cs_d, dc_d, res_n_d, done_d, last, wr_op;
   logic [1:0]        op;
   logic [DATA_W-1:0] payload;
   assign op          = instr[DATA_W+1:DATA_W];
   assign payload     = instr[DATA_W-1:0];
   assign wr_op       = !op[1];
   assign instr_ready = state == ST_IDLE;
   assign busy        = !instr_ready;
   display_word_shifter #(.DATA_W(DATA_W)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (instr_valid && instr_ready && wr_op),
      .shift (state == ST_SHIFT && sclk_edge),
      .din   (payload),
      .mosi  (mosi),
      .last  (last)
   );
   // state, counter and pin registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         cs    <= 1'b1;
         dc    <= 1'b1;
         res_n <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         cs    <= cs_d;
         dc    <= dc_d;
         res_n <= res_n_d;
         done  <= done_d;
      end
   end
   // next state and pin values; strobes are only counted after the accept cycle
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cs_d    = cs;
      dc_d    = dc;
      res_n_d = res_n;
      done_d  = 1'b0;
      case (state)
         ST_IDLE: if (instr_valid) begin
            state_d = wr_op ? ST_SHIFT : op == OP_DELAY ? ST_DELAY : ST_RESET;
            cnt_d   = op == OP_DELAY ? CW'(payload) << DELAY_SHIFT : op == OP_RESET ? CW'(RES_EDGES) : '0;
            cs_d    = !wr_op;
            dc_d    = wr_op ? !op[0] : dc;
            res_n_d = op != OP_RESET;
         end
         ST_SHIFT: if (sclk_edge && last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`ifdef CS_HOLD_EN
            cs_d    = 1'b0;
`else
            cs_d    = 1'b1;
`endif
         end
         ST_DELAY: begin
            if (sclk_edge && cnt != '0) cnt_d = cnt - CW'(1);
            if (cnt == '0 || (sclk_edge && cnt == CW'(1))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_RESET: begin
            if (sclk_edge) cnt_d = cnt - CW'(1);
            if (sclk_edge && cnt == CW'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               res_n_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
endmodule
